// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch predict unit
package branch_pkg;

    typedef enum logic [1:0] {
        NO_CTRL = 2'b00,
        JAL     = 2'b01,
        JALR    = 2'b10,
        BRANCH  = 2'b11
    } branch_op_e;

    localparam logic [31:0] HALT_PC = 32'hFFFF_FFFF;
    localparam logic [1:0]  CTR_ST  = 2'b11;
    localparam logic [1:0]  CTR_WT  = 2'b10;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB storage with one lookup and one write port
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(ENTRIES)-1:0]  rd_idx,
    input  logic [TAG_W-1:0]            rd_tag,
    output logic                        rd_hit,
    output logic                        rd_taken,
    output logic [31:0]                 rd_target,
    input  logic [$clog2(ENTRIES)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]            wr_tag,
    output logic                        wr_hit,
    output logic [1:0]                  wr_ctr_old,
    input  logic                        wr_en,
    input  logic                        wr_inv,
    input  logic                        wr_keep_target,
    input  logic [31:0]                 wr_target,
    input  logic [1:0]                  wr_ctr
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    assign rd_hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_taken   = ctr_mem[rd_idx][1];
    assign rd_target  = target_mem[rd_idx];

    // Write-side tag check lets the owner do read-modify-write of the counter.
    assign wr_hit     = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
    assign wr_ctr_old = ctr_mem[wr_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end else if (wr_inv) begin
            valid[wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            ctr_mem[wr_idx] <= wr_ctr;
            if (!wr_keep_target)
                target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - IF-side BTB prediction and EX-side branch resolution
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_WIDTH   = 9,
    parameter int ENTRIES    = 16,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  ex_valid,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [31:0]           ex_imm,
    input  logic [1:0]            ex_branch_op,
    input  logic                  ex_halt,
    input  logic [31:0]           ex_alu_result,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic [31:0]           branch_pc,
    output logic [31:0]           pc_plus_4,
    output logic                  pc_sel,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic                  halted,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    branch_op_e  op;
    logic [31:0] pc_ext;
    logic        rd_hit, rd_taken, wr_hit;
    logic [31:0] rd_target;
    logic [1:0]  wr_ctr_old, wr_ctr;
    logic        wr_en, wr_inv, wr_keep_target;
    logic        mismatch, upd_en, is_ctrl;
    logic        unused_pc_bits;

    assign op             = branch_op_e'(ex_branch_op);
    assign pc_ext         = 32'(ex_pc);
    assign pc_plus_4      = pc_ext + 32'd4;
    assign unused_pc_bits = ^if_pc[1:0];

    branch_target_buffer #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk            (clk),
        .reset          (reset),
        .rd_idx         (if_pc[IDX_W+1:2]),
        .rd_tag         (if_pc[PC_WIDTH-1:IDX_W+2]),
        .rd_hit         (rd_hit),
        .rd_taken       (rd_taken),
        .rd_target      (rd_target),
        .wr_idx         (ex_pc[IDX_W+1:2]),
        .wr_tag         (ex_pc[PC_WIDTH-1:IDX_W+2]),
        .wr_hit         (wr_hit),
        .wr_ctr_old     (wr_ctr_old),
        .wr_en          (wr_en),
        .wr_inv         (wr_inv),
        .wr_keep_target (wr_keep_target),
        .wr_target      (branch_pc),
        .wr_ctr         (wr_ctr)
    );

    assign pred_taken  = rd_hit && rd_taken && !halted && !reset;
    assign pred_target = pred_taken ? rd_target : 32'd0;

    always_comb begin
        pc_sel    = 1'b0;
        branch_pc = 32'd0;
        if (ex_valid) begin
            if (ex_halt) begin
                pc_sel    = 1'b1;
                branch_pc = HALT_PC;
            end else begin
                case (op)
                    JAL: begin
                        pc_sel    = 1'b1;
                        branch_pc = pc_ext + ex_imm;
                    end
                    JALR: begin
                        pc_sel    = 1'b1;
                        branch_pc = (pc_ext + ex_alu_result) & 32'hFFFF_FFFE;
                    end
                    BRANCH: begin
                        pc_sel    = ex_alu_result[0];
                        branch_pc = pc_ext + ex_imm;
                    end
                    default: begin
                        pc_sel    = 1'b0;
                        branch_pc = 32'd0;
                    end
                endcase
            end
        end
    end

    // Halt redirects unconditionally so the fetch stream parks at HALT_PC.
    assign mismatch    = (pc_sel != ex_pred_taken) || (pc_sel && (branch_pc != ex_pred_target));
    assign redirect    = ex_valid && !halted && !reset && (ex_halt || mismatch);
    assign redirect_pc = pc_sel ? branch_pc : pc_plus_4;

    assign upd_en  = ex_valid && !halted && !ex_halt && !reset;
    assign is_ctrl = upd_en && (op != NO_CTRL);

    always_comb begin
        wr_en          = 1'b0;
        wr_inv         = 1'b0;
        wr_keep_target = 1'b0;
        wr_ctr         = CTR_ST;
        if (upd_en) begin
            case (op)
                JAL, JALR: wr_en = 1'b1;
                BRANCH: begin
                    if (wr_hit) begin
                        wr_en          = 1'b1;
                        wr_ctr         = ctr_update(wr_ctr_old, pc_sel);
                        wr_keep_target = !pc_sel;
                    end else if (pc_sel) begin
                        wr_en  = 1'b1;
                        wr_ctr = CTR_WT;
                    end
                end
                default: wr_inv = wr_hit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted           <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid && ex_halt)
                halted <= 1'b1;
            if (is_ctrl && (branch_count != '1))
                branch_count <= branch_count + STAT_WIDTH'(1);
            if (redirect && (mispredict_count != '1))
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;
    import branch_pkg::*;

    localparam int PW = 9;
    localparam int SW = 8;

    localparam int P_TK = 0, P_TG = 1, RD = 2, RPC = 3, PSEL = 4, BPC = 5, HLT = 6, BCNT = 7, MCNT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] if_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          ex_valid;
    logic [PW-1:0] ex_pc;
    logic [31:0]   ex_imm;
    logic [1:0]    ex_branch_op;
    logic          ex_halt;
    logic [31:0]   ex_alu_result;
    logic          ex_pred_taken;
    logic [31:0]   ex_pred_target;
    logic [31:0]   branch_pc, pc_plus_4, redirect_pc;
    logic          pc_sel, redirect, halted;
    logic [SW-1:0] branch_count, mispredict_count;

    branch_predict_unit #(.PC_WIDTH(PW), .ENTRIES(16), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch_op(ex_branch_op), .ex_halt(ex_halt), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .branch_pc(branch_pc), .pc_plus_4(pc_plus_4), .pc_sel(pc_sel),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   next_id = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int sel);
        case (sel)
            P_TK:    return "pred_taken";
            P_TG:    return "pred_target";
            RD:      return "redirect";
            RPC:     return "redirect_pc";
            PSEL:    return "pc_sel";
            BPC:     return "branch_pc";
            HLT:     return "halted";
            BCNT:    return "branch_count";
            default: return "mispredict_count";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            P_TK:    return 32'(pred_taken);
            P_TG:    return pred_target;
            RD:      return 32'(redirect);
            RPC:     return redirect_pc;
            PSEL:    return 32'(pc_sel);
            BPC:     return branch_pc;
            HLT:     return 32'(halted);
            BCNT:    return 32'(branch_count);
            default: return 32'(mispredict_count);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL #%0d %s: not sampled in cycle %0d (now %0d)", e.id, sel_name(e.sel), e.cyc, cyc);
            end else begin
                act = sample(e.sel);
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL #%0d %s: got %h expected %h", e.id, sel_name(e.sel), act, e.val);
                end
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.id  = next_id;
        e.sel = sel;
        e.val = v;
        next_id++;
        q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic v, input logic [1:0] op, input logic h,
                         input logic [PW-1:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                         input logic pt, input logic [31:0] ptg, input logic [PW-1:0] ipc);
        @(posedge clk);
        #1;
        reset          = rst;
        ex_valid       = v;
        ex_branch_op   = op;
        ex_halt        = h;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_alu_result  = alu;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        if_pc          = ipc;
    endtask

    task automatic idle(input logic [PW-1:0] ipc);
        drive(1'b0, 1'b0, NO_CTRL, 1'b0, '0, 32'd0, 32'd0, 1'b0, 32'd0, ipc);
    endtask

    initial begin
        int w;
        reset = 1'b1; ex_valid = 1'b0; ex_branch_op = NO_CTRL; ex_halt = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_alu_result = '0; ex_pred_taken = 1'b0;
        ex_pred_target = '0; if_pc = 9'h040;

        // reset cycles: a would-be mispredict must not redirect
        drive(1'b1, 1'b1, NO_CTRL, 1'b0, 9'h004, 32'd0, 32'd0, 1'b1, 32'h104, 9'h040);
        expect_val(P_TK, 0); expect_val(P_TG, 0); expect_val(RD, 0);
        drive(1'b1, 1'b1, NO_CTRL, 1'b0, 9'h004, 32'd0, 32'd0, 1'b1, 32'h104, 9'h040);
        expect_val(RD, 0);
        idle(9'h040);
        expect_val(P_TK, 0); expect_val(P_TG, 0); expect_val(BCNT, 0); expect_val(MCNT, 0);
        expect_val(HLT, 0); expect_val(PSEL, 0); expect_val(RD, 0);

        // taken branch, miss: allocate ctr=2
        drive(1'b0, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd1, 1'b0, 32'd0, 9'h040);
        expect_val(RD, 1); expect_val(RPC, 32'h60); expect_val(PSEL, 1); expect_val(BPC, 32'h60);
        expect_val(P_TK, 0);
        idle(9'h040);
        expect_val(P_TK, 1); expect_val(P_TG, 32'h60); expect_val(BCNT, 1); expect_val(MCNT, 1);

        // not taken twice: 2 -> 1 -> 0
        drive(1'b0, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd0, 1'b1, 32'h60, 9'h040);
        expect_val(RD, 1); expect_val(RPC, 32'h44); expect_val(PSEL, 0); expect_val(P_TK, 1);
        idle(9'h040);
        expect_val(P_TK, 0); expect_val(P_TG, 0); expect_val(BCNT, 2); expect_val(MCNT, 2);
        drive(1'b0, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd0, 1'b0, 32'd0, 9'h040);
        expect_val(RD, 0); expect_val(RPC, 32'h44);
        idle(9'h040);
        expect_val(P_TK, 0); expect_val(BCNT, 3); expect_val(MCNT, 2);
        // counter at 0: one taken only reaches 1, still predicting not taken
        drive(1'b0, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd1, 1'b0, 32'd0, 9'h040);
        expect_val(RD, 1); expect_val(RPC, 32'h60);
        idle(9'h040);
        expect_val(P_TK, 0); expect_val(BCNT, 4); expect_val(MCNT, 3);

        // JALR correct prediction, then target change
        drive(1'b0, 1'b1, JALR, 1'b0, 9'h010, 32'd0, 32'h31, 1'b1, 32'h40, 9'h010);
        expect_val(RD, 0); expect_val(BPC, 32'h40); expect_val(PSEL, 1); expect_val(RPC, 32'h40);
        idle(9'h010);
        expect_val(P_TK, 1); expect_val(P_TG, 32'h40);
        drive(1'b0, 1'b1, JALR, 1'b0, 9'h010, 32'd0, 32'h51, 1'b1, 32'h40, 9'h010);
        expect_val(RD, 1); expect_val(RPC, 32'h60);
        idle(9'h010);
        expect_val(P_TG, 32'h60); expect_val(BCNT, 6); expect_val(MCNT, 4);

        // JAL fills index 1; tag mismatch at 0x044; NO_CTRL alias invalidates
        drive(1'b0, 1'b1, JAL, 1'b0, 9'h004, 32'h100, 32'd0, 1'b0, 32'd0, 9'h004);
        expect_val(RD, 1); expect_val(RPC, 32'h104);
        idle(9'h004);
        expect_val(P_TK, 1); expect_val(P_TG, 32'h104); expect_val(BCNT, 7); expect_val(MCNT, 5);
        idle(9'h044);
        expect_val(P_TK, 0);
        drive(1'b0, 1'b1, NO_CTRL, 1'b0, 9'h004, 32'd0, 32'd0, 1'b1, 32'h104, 9'h004);
        expect_val(RD, 1); expect_val(RPC, 32'h008); expect_val(PSEL, 0); expect_val(BPC, 0);
        idle(9'h004);
        expect_val(P_TK, 0); expect_val(MCNT, 6); expect_val(BCNT, 7);

        // 32-bit wraparound of pc + imm
        drive(1'b0, 1'b1, JAL, 1'b0, 9'h1FC, 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFC, 9'h004);
        expect_val(BPC, 32'hFC); expect_val(RD, 0);
        idle(9'h1FC);
        expect_val(P_TK, 1); expect_val(P_TG, 32'hFC); expect_val(BCNT, 8);

        // halt, then frozen state
        drive(1'b0, 1'b1, NO_CTRL, 1'b1, 9'h020, 32'd0, 32'd0, 1'b0, 32'd0, 9'h010);
        expect_val(RD, 1); expect_val(RPC, 32'hFFFF_FFFF); expect_val(PSEL, 1); expect_val(HLT, 0);
        expect_val(P_TK, 1);
        drive(1'b0, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd1, 1'b0, 32'd0, 9'h010);
        expect_val(RD, 0); expect_val(P_TK, 0); expect_val(P_TG, 0); expect_val(HLT, 1);
        expect_val(MCNT, 7); expect_val(BCNT, 8);
        idle(9'h010);
        expect_val(HLT, 1); expect_val(MCNT, 7); expect_val(BCNT, 8);

        // mid-operation reset clears everything
        drive(1'b1, 1'b1, BRANCH, 1'b0, 9'h040, 32'h20, 32'd1, 1'b0, 32'd0, 9'h010);
        expect_val(RD, 0); expect_val(P_TK, 0);
        idle(9'h010);
        expect_val(HLT, 0); expect_val(P_TK, 0); expect_val(BCNT, 0); expect_val(MCNT, 0);

        // mispredict counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, NO_CTRL, 1'b0, 9'h100, 32'd0, 32'd0, 1'b1, 32'h200, 9'h000);
            if (i == 0) begin
                expect_val(RD, 1); expect_val(RPC, 32'h104);
            end
        end
        idle(9'h000);
        expect_val(MCNT, 32'hFF); expect_val(BCNT, 0);
        drive(1'b0, 1'b1, NO_CTRL, 1'b0, 9'h100, 32'd0, 32'd0, 1'b1, 32'h200, 9'h000);
        expect_val(RD, 1);
        idle(9'h000);
        expect_val(MCNT, 32'hFF);

        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
            errors = errors + q.size();
            checks = checks + q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch resolver. It pairs a fetch-side direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters and an EX-side resolver that computes the actual next PC for JAL, JALR, BRANCH and halt. The EX-side resolver compares the actual outcome against the prediction carried down the pipeline and raises a one-cycle redirect on mispredict. It sits between IF (lookup) and EX (resolve and update) of the 5-stage RISC-V pipeline.

## Interface
- PC_WIDTH, 9: width of instruction PCs; must satisfy PC_WIDTH >= log2(ENTRIES)+3
- ENTRIES, 16: BTB entries, power of two, 2..256
- STAT_WIDTH, 16: width of statistics counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_pc  in  PC_WIDTH  fetch-stage PC to look up
- pred_taken  out  1  IF prediction: taken
- pred_target  out  32  IF predicted target; 0 when pred_taken=0
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_pc  in  PC_WIDTH  PC of EX instruction
- ex_imm  in  32  immediate of EX instruction
- ex_branch_op  in  2  NO_CTRL/JAL/JALR/BRANCH
- ex_halt  in  1  EX instruction is halt
- ex_alu_result  in  32  ALU output; bit0 = branch condition for BRANCH, offset for JALR
- ex_pred_taken  in  1  prediction made for this instruction at IF
- ex_pred_target  in  32  predicted target made at IF
- branch_pc  out  32  actual control-transfer target
- pc_plus_4  out  32  zero-extended ex_pc + 4
- pc_sel  out  1  actual outcome taken
- redirect  out  1  mispredict; flush IF/ID and refetch
- redirect_pc  out  32  correct next PC when redirect=1
- halted  out  1  sticky halt flag
- branch_count, mispredict_count  out  STAT_WIDTH each  statistics

## Operation
- Index = pc[IDX_W+1:2], with IDX_W = log2(ENTRIES). Tag = pc[PC_WIDTH-1:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup is combinational from registered state. hit = valid && tag match. pred_taken = hit && ctr[1] && !halted.
- Actual outcome, computed only when ex_valid:
  - halt: pc_sel=1, branch_pc=32'hFFFFFFFF.
  - JAL: taken, target = pc + imm.
  - JALR: taken, target = (pc + alu_result) & 32'hFFFFFFFE.
  - BRANCH: taken = alu_result[0], target = pc + imm.
  - NO_CTRL: not taken, branch_pc=0.
  - All sums are 32-bit with the PC zero-extended; overflow wraps.
- redirect = ex_valid && !halted && (pc_sel != ex_pred_taken || (pc_sel && branch_pc != ex_pred_target)).
- redirect_pc = pc_sel ? branch_pc : pc_plus_4.
- Halt always redirects to 32'hFFFFFFFF. On the next edge, halted is set; it stays set until reset.
- While halted: no BTB or statistics updates, pred_taken=0, redirect=0.
- Update at the clock edge when ex_valid && !halted && !ex_halt:
  - JAL/JALR: write entry (valid=1, tag, target, ctr=3).
  - BRANCH, hit: ctr saturating ++ if taken, -- if not taken. Target rewritten if taken.
  - BRANCH, miss and taken: allocate with ctr=2.
  - BRANCH, miss and not taken: no write.
  - NO_CTRL, hit: invalidate the entry (alias cleanup).
- branch_count increments on each updating JAL/JALR/BRANCH. mispredict_count increments on each redirect. Both saturate at all-ones.

## Timing
- Prediction has zero latency: pred_* is valid in the same cycle as if_pc.
- Resolution has zero latency: branch_pc, pc_sel and redirect are valid in the same cycle as the EX inputs.
- Table update is visible to a lookup starting the cycle after the edge. There is no bypass: a same-cycle lookup and update of one index returns the old entry.
- redirect is one cycle per mispredicting instruction. The caller flushes younger stages.
- Reset, including mid-operation: all valid=0, ctr contents don't-care, halted=0, counters=0. In the reset cycle pred_taken=0, pred_target=0, and redirect is forced 0.
- ex_valid=0 implies redirect=0, pc_sel=0, and no state change.

## Structure
- Package branch_pkg holds:
  - branch_op_e enum: NO_CTRL=2'b00, JAL=2'b01, JALR=2'b10, BRANCH=2'b11.
  - HALT_PC = 32'hFFFFFFFF.
  - CTR_ST=2'b11 and CTR_WT=2'b10.
- Sub-module branch_target_buffer (parameters ENTRIES, TAG_W) contains the entry storage, one combinational read port and one synchronous write/invalidate port. The top holds the resolver, update policy, halt flag and statistics.

## Test plan
- Reset, then if_pc=0x040: pred_taken=0, pred_target=0; counters=0.
- BRANCH at ex_pc=0x040, imm=0x20, alu_result=1, ex_pred_taken=0: redirect=1, redirect_pc=0x060. Next cycle, lookup of 0x040 gives pred_taken=1, pred_target=0x060.
- Same branch not taken twice with ex_pred_taken=1: first occurrence redirects to 0x044 with ctr 2→1; lookup then gives pred_taken=0; second occurrence has no redirect; ctr=0.
- JALR at ex_pc=0x010, alu_result=0x31, predicted taken to 0x040: actual target 0x040, redirect=0. A second JALR with alu_result=0x51 gives redirect_pc=0x060, and the entry target becomes 0x060.
- ex_halt=1, ex_valid=1: redirect=1, redirect_pc=0xFFFFFFFF. Subsequent BRANCH traffic gives redirect=0, no count change, halted=1 until reset.
- Aliasing: ENTRIES=16, JAL at 0x004 fills index 1. A NO_CTRL instruction at 0x004 predicted taken gives redirect=1, redirect_pc=0x008, and the entry is invalidated. Saturation check: run mispredicts beyond 2^STAT_WIDTH and confirm mispredict_count holds at all-ones.
